pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing stage that consumes the branch-target lookup table's output.
- Holds the 10-bit program counter and runs a start/done/ack handshake with the top-level test harness.
- Evaluates branch conditions and chooses the next PC. The chosen PC is either sequential or the absolute target returned by the branch lookup.
- Forwards the instruction's 8-bit branch index to the lookup table and receives its 10-bit target back in the same cycle.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/branch_cond_eval.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 97 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and widths for the program-counter / fetch-sequencing stage.
package pc_pkg;

  localparam int PC_W  = 10;
  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } pc_state_t;

  typedef enum logic [1:0] {
    C_ALWAYS = 2'b00,
    C_ZERO   = 2'b01,
    C_NZERO  = 2'b10,
    C_NEG    = 2'b11
  } cond_sel_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch decision: take is high only for a branch whose
// selected condition holds.
module branch_cond_eval (
  input  logic       branch_en,
  input  logic [1:0] cond_sel,
  input  logic       zero_flag,
  input  logic       neg_flag,
  output logic       take
);
  import pc_pkg::*;

  logic cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel_t'(cond_sel))
      C_ALWAYS: cond_true = 1'b1;
      C_ZERO:   cond_true = zero_flag;
      C_NZERO:  cond_true = ~zero_flag;
      C_NEG:    cond_true = neg_flag;
      default:  cond_true = 1'b0;
    endcase
  end

  assign take = branch_en & cond_true;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, next-PC
// selection from sequential or lookup-table targets, saturating RUN counter.
module pc_fetch_ctrl #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             ack,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [1:0]       cond_sel,
  input  logic             zero_flag,
  input  logic             neg_flag,
  input  logic [IDX_W-1:0] branch_idx,
  output logic [IDX_W-1:0] lut_index,
  input  logic [PC_W-1:0]  branch_addr,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state_dbg
);
  import pc_pkg::*;

  // Harness handshake: start is a request seen only in IDLE; done stays high
  // for the whole HALTED stay and drops the cycle after ack is seen; a fresh
  // start must follow once IDLE is reached again.

  pc_state_t state;
  logic      take;

  // The lookup table has zero latency, so its target is usable this cycle.
  assign lut_index = branch_idx;
  assign state_dbg = state;

  branch_cond_eval u_cond (
    .branch_en (branch_en),
    .cond_sel  (cond_sel),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
    .take      (take)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      cycle_cnt <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            prog_ctr  <= START_ADDR;
            cycle_cnt <= '0;
            running   <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          // Every RUN cycle counts, including stalls and the halt cycle.
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
          if (halt_req) begin
            state   <= HALTED;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (stall) begin
            prog_ctr <= prog_ctr;
          end else if (take) begin
            prog_ctr <= branch_addr;
          end else begin
            prog_ctr <= prog_ctr + PC_W'(1);
          end
        end
        HALTED: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed and random stimulus, expectations from a
// behavioural model pushed to a queue and popped by an independent monitor.
module tb_pc_fetch_ctrl;
  import pc_pkg::*;

  localparam int EW = 30;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, start = 1'b0, ack = 1'b0, halt_req = 1'b0, stall = 1'b0;
  logic       branch_en = 1'b0, zero_flag = 1'b0, neg_flag = 1'b0;
  logic [1:0] cond_sel = 2'b00;
  logic [7:0] branch_idx = 8'h00;
  logic [7:0] lut_index;
  logic [9:0] branch_addr = 10'h000;
  logic [9:0] prog_ctr;
  logic       running, done;
  logic [15:0] cycle_cnt;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  // Model: 0 = idle, 1 = run, 2 = halted.
  int m_st = 0;
  int m_pc = 0;
  int m_cnt = 0;

  pc_fetch_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .ack        (ack),
    .halt_req   (halt_req),
    .stall      (stall),
    .branch_en  (branch_en),
    .cond_sel   (cond_sel),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .branch_idx (branch_idx),
    .lut_index  (lut_index),
    .branch_addr(branch_addr),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .cycle_cnt  (cycle_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_pack();
    logic [1:0] s;
    s = (m_st == 1) ? 2'(RUN) : (m_st == 2) ? 2'(HALTED) : 2'(IDLE);
    return {s, 10'(m_pc), 16'(m_cnt), (m_st == 1), (m_st == 2)};
  endfunction

  // Driver: apply one cycle of inputs, advance the model, queue the expectation.
  task automatic step(input logic r, input logic s, input logic a, input logic h,
                      input logic st, input logic be, input logic [1:0] cs,
                      input logic z, input logic n, input logic [7:0] idx,
                      input logic [9:0] addr);
    bit cond;
    @(negedge Clk);
    Reset = r; start = s; ack = a; halt_req = h; stall = st; branch_en = be;
    cond_sel = cs; zero_flag = z; neg_flag = n; branch_idx = idx; branch_addr = addr;
    #1;
    check("lut_index", 32'(lut_index), 32'(idx));
    cond = (cs == 2'b00) ? 1'b1 : (cs == 2'b01) ? z : (cs == 2'b10) ? !z : n;
    if (r) begin
      m_st = 0; m_pc = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (s) begin m_st = 1; m_pc = 0; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (h) m_st = 2;
      else if (st) m_pc = m_pc;
      else if (be && cond) m_pc = int'(addr);
      else m_pc = (m_pc + 1) % 1024;
    end else begin
      if (a) m_st = 0;
    end
    exp_q.push_back(model_pack());
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
  endtask

  task automatic jump(input logic [9:0] t);
    step(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 8'h11, t);
  endtask

  // Scoreboard monitor: one expectation per clock edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",     32'(state_dbg), 32'(e[29:28]));
        check("prog_ctr",  32'(prog_ctr),  32'(e[27:18]));
        check("cycle_cnt", 32'(cycle_cnt), 32'(e[17:2]));
        check("running",   32'(running),   32'(e[1]));
        check("done",      32'(done),      32'(e[0]));
        check("excl",      32'(running & done), 32'(0));
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(1, 1, 1, 1, 1, 1, 2'b00, 1, 1, 8'hFF, 10'h3FF);
    nop();
    // Start and run sequentially, then conditional branches at PC=3
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    repeat (3) nop();
    step(0, 0, 0, 0, 0, 1, 2'b01, 1, 0, 8'h2A, 10'h155);
    step(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 8'h2A, 10'h155);
    jump(10'd3);
    step(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 8'h2A, 10'h155);
    step(0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 8'h05, 10'h0A0);
    step(0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 8'h06, 10'h0B0);
    step(0, 0, 0, 0, 0, 1, 2'b11, 1, 0, 8'h07, 10'h0C0);
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8'h08, 10'h0D0);
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    // Stall beats a true branch; branch goes once stall drops; halt beats stall
    step(0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 8'h33, 10'h200);
    step(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 8'h33, 10'h200);
    step(0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 8'h33, 10'h300);
    repeat (2) nop();
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    // Wrap 1022 -> 1023 -> 0, and a self-loop branch
    jump(10'd1022);
    repeat (3) nop();
    jump(10'd1);
    jump(10'd1);
    // Halt at PC=7, start ignored while halted, ack, restart
    jump(10'd7);
    step(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    // Reset mid-RUN at PC=40
    jump(10'd40);
    step(1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 8'h00, 10'h100);
    nop();
    // Counter saturation
    step(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    repeat (65540) nop();
    step(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    step(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 10'h000);
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           10'($urandom_range(0, 1023)));
    end
    repeat (3) @(negedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
